// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU,
// MTHI and MTLO. Multiplies take one cycle after acceptance; divides run a
// 32-step restoring divider. busy stalls the pipeline while an op is in flight.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   start  - request strobe, sampled only while idle
//   op     - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x nop
//   flush  - synchronous cancel of an in-flight op; also discards a same-cycle start
//   busA   - rs operand (dividend / multiplicand / MTHI-MTLO data)
//   busB   - rt operand (divisor / multiplier)
//   busy   - high while a multiply or divide is in flight
//   done   - one-cycle pulse after HI/LO are written by a multiply or divide
//   hi, lo - HI/LO registers, driven straight from their flops
module mul_div_unit #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] busA,
  input  logic [31:0] busB,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  localparam int unsigned CntW = $clog2(DIV_CYCLES) + 1;
  localparam logic [CntW-1:0] LastStep = CntW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_t;

  state_t          r_state;
  logic [31:0]     r_hi;
  logic [31:0]     r_lo;
  logic            r_busy;
  logic            r_done;
  logic [31:0]     r_a;         // raw busA: multiplicand, or divide-by-zero HI value
  logic [31:0]     r_b;         // multiplier, or divisor magnitude
  logic            r_signed;    // multiply is signed
  logic            r_neg_q;     // negate quotient at the end
  logic            r_neg_r;     // negate remainder at the end
  logic            r_div_zero;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_rem;
  logic [31:0]     r_quo;       // dividend bits shift out as quotient bits shift in

  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic [32:0] w_rem_sh;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_q_fin;
  logic [31:0] w_r_fin;

  always_comb begin
    w_abs_a = busA[31] ? -busA : busA;
    w_abs_b = busB[31] ? -busB : busB;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
    // correct for both signed and unsigned operands.
    w_mul_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'b0, r_a};
    w_mul_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'b0, r_b};
    w_prod  = w_mul_a * w_mul_b;

    // One restoring step: shift {rem, quo} left, subtract divisor if it fits.
    w_rem_sh = {r_rem, r_quo[31]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    w_ge     = (w_rem_sh >= {1'b0, r_b});
    w_rem_nx = w_ge ? w_diff[31:0] : w_rem_sh[31:0];
    w_quo_nx = {r_quo[30:0], w_ge};

    w_q_fin = r_neg_q ? -w_quo_nx : w_quo_nx;
    w_r_fin = r_neg_r ? -w_rem_nx : w_rem_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div_zero <= 1'b0;
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // flush discards a request arriving in the same cycle
          if (start && !flush) begin
            case (op)
              OpMult, OpMultu: begin
                r_a      <= busA;
                r_b      <= busB;
                r_signed <= (op == OpMult);
                r_state  <= StMul;
                r_busy   <= 1'b1;
              end
              OpDiv, OpDivu: begin
                r_a        <= busA;
                r_b        <= (op == OpDiv) ? w_abs_b : busB;
                r_quo      <= (op == OpDiv) ? w_abs_a : busA;
                r_rem      <= '0;
                r_neg_q    <= (op == OpDiv) && (busA[31] ^ busB[31]);
                r_neg_r    <= (op == OpDiv) && busA[31];
                r_div_zero <= (busB == 32'b0);
                r_cnt      <= '0;
                r_state    <= StDiv;
                r_busy     <= 1'b1;
              end
              OpMthi:  r_hi <= busA;
              OpMtlo:  r_lo <= busA;
              default: ;
            endcase
          end
        end
        StMul: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          if (!flush) begin
            r_hi   <= w_prod[63:32];
            r_lo   <= w_prod[31:0];
            r_done <= 1'b1;
          end
        end
        StDiv: begin
          if (flush) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (r_cnt == LastStep) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (r_div_zero) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_r_fin;
              r_lo <= w_q_fin;
            end
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage, beside the single-cycle ALU.
- Executes the HI/LO-class instructions the ALU does not handle: MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers.
- Raises busy so the hazard unit stalls the pipeline while an operation is in flight.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles in a divide. Fixed at 32 for a 32-bit datapath; any other value is out of scope.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request strobe; sampled on clk edges only while idle.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no operation.
- flush  input  1  synchronous cancel of any in-flight operation (exception or branch flush).
- busA  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data).
- busB  input  32  rt operand (divisor / multiplier).
- busy  output  1  high while a multiply or divide is in flight.
- done  output  1  one-cycle pulse after HI/LO are written by a MULT, MULTU, DIV or DIVU.
- hi  output  32  HI register, driven directly from its flop.
- lo  output  32  LO register, driven directly from its flop.

Behaviour:
- Reset (asynchronous, any time including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Operand and iteration registers cleared.
- States: IDLE, MUL, DIV.
- Acceptance:
  - start=1 in IDLE is sampled at edge E0.
  - start is ignored in MUL and DIV; the pipeline is already stalled on busy.
  - Ops 11x are a no-operation: no state change.
- MTHI / MTLO: at E0, hi (resp. lo) <= busA. The other register is untouched, state stays IDLE, busy and done stay low.
- MULT / MULTU:
  - At E0: capture operands, state=MUL, busy=1.
  - At E1: {hi,lo} <= 64-bit product (signed for MULT, unsigned for MULTU); state=IDLE, busy=0, done=1 for exactly one cycle.
- DIV / DIVU:
  - At E0: capture magnitudes (|busA|, |busB| for DIV, raw values for DIVU), the sign flags and a divisor-zero flag; iteration counter=0; state=DIV, busy=1.
  - Each edge E1..E32: one restoring-division step (shift the remainder:quotient pair left by one; subtract the divisor when the remainder is >= divisor).
  - At E32: result written, state=IDLE, busy=0; done=1 during the cycle after E32.
  - Signed correction (DIV): quotient negated when the operand signs differ; remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
- Divide by zero (DIV or DIVU): same 32-cycle latency; lo=32'hFFFFFFFF, hi=captured busA (unmodified).
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. No trap.
- flush:
  - In MUL or DIV: at the next edge, state=IDLE, busy=0, no done, and hi/lo keep their prior values.
  - flush and start in the same cycle: flush wins and the request is discarded.
  - flush in IDLE: no effect.
  - flush on the same edge the result would be written: the write is suppressed.
- busy and done are registered (no combinational path from the inputs).
- done is never high while busy is high.
- hi and lo change only on a result write, an MTHI/MTLO, or reset.

Test Plan:
- MULT busA=0xFFFFFFFE, busB=3 -> busy high one cycle, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done pulses once. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIVU busA=100, busB=7 -> busy high for exactly 32 cycles, then lo=0x0000000E, hi=0x00000002, done for one cycle. DIV busA=0xFFFFFFF9 (-7), busB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV busA=0x80000000, busB=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU busA=5, busB=0 -> lo=0xFFFFFFFF, hi=0x00000005 after 32 cycles.
- Preload via MTHI 0x1234, MTLO 0x5678 (hi/lo update next edge, busy never rises). Then start a DIV and assert flush on the 10th busy cycle -> busy drops next edge, no done, hi=0x1234, lo=0x5678. A start during busy is also ignored.
- Assert rst asynchronously mid-divide -> hi=lo=0, busy=done=0 immediately. A new MULTU 0x10000 x 0x10000 after release -> hi=1, lo=0.
- Issue start together with flush while IDLE with DIVU -> no busy and no done; a start with op=110 -> no state change.
